// File: rtl/rs_syndrome_calc_if.sv
// Handshake bundle for the RS(15,9) syndrome calculator: the symbol stream in,
// the syndrome result out, and the busy flag.
interface rs_syndrome_calc_if;
  logic [3:0]  symIn;
  logic        symValid;
  logic        symReady;
  logic [23:0] syndromeOut;
  logic        syndromeValid;
  logic        syndromeReady;
  logic        errorDetected;
  logic        busy;

  modport master (
    output symIn, symValid, syndromeReady,
    input  symReady, syndromeOut, syndromeValid, errorDetected, busy
  );

  modport slave (
    input  symIn, symValid, syndromeReady,
    output symReady, syndromeOut, syndromeValid, errorDetected, busy
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Symbol-serial RS(15,9) syndrome calculator over GF(16) (x^4+x+1): Horner
// evaluation of S1..S6 = r(alpha^j) on a word streamed r14 first.
module rs_syndrome_calc (
  input logic clk,
  input logic resetN,
  rs_syndrome_calc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} fsmState;

  fsmState          stateReg;
  logic [3:0]       cntReg;
  logic [5:0][3:0]  synReg;
  logic [5:0][3:0]  synNext;
  logic             validReg;
  logic             busyReg;
  logic             symReadyInt;
  logic             accept;
  logic             consume;

  function automatic logic [3:0] mulAlpha(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'b0011 : 4'b0000);
  endfunction

  // Constant multiply by alpha^n as n chained alpha steps; n is a genvar, so
  // this flattens into a fixed XOR network per syndrome.
  function automatic logic [3:0] mulPow(input logic [3:0] a, input int n);
    logic [3:0] r;
    r = a;
    for (int k = 0; k < 6; k++) begin
      if (k < n) r = mulAlpha(r);
    end
    return r;
  endfunction

  assign symReadyInt = (stateReg != HOLD);
  assign accept      = bus.symValid && symReadyInt;
  assign consume     = validReg && bus.syndromeReady;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : genSyn
      // The first symbol seeds the accumulator, so the previous word's
      // syndromes never leak into the next one.
      assign synNext[gi] = (stateReg == IDLE) ? bus.symIn
                                              : (mulPow(synReg[gi], gi + 1) ^ bus.symIn);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetN) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      synReg   <= '0;
      validReg <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (accept) begin
            synReg   <= synNext;
            cntReg   <= 4'd1;
            stateReg <= ACCUM;
            busyReg  <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            synReg <= synNext;
            if (cntReg == 4'd14) begin
              cntReg   <= 4'd0;
              stateReg <= HOLD;
              validReg <= 1'b1;
            end else begin
              cntReg <= cntReg + 4'd1;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            stateReg <= IDLE;
            validReg <= 1'b0;
            busyReg  <= 1'b0;
          end
        end
        default: begin
          stateReg <= IDLE;
          cntReg   <= 4'd0;
          validReg <= 1'b0;
          busyReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.symReady      = symReadyInt;
  assign bus.syndromeOut   = synReg;
  assign bus.syndromeValid = validReg;
  assign bus.errorDetected = |synReg;
  assign bus.busy          = busyReg;

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: log/antilog GF(16) model computing
// r(alpha^j) directly as a sum, plus hand-computed literal syndromes.
module tb_rs_syndrome_calc;
  logic clk;
  logic resetN;
  rs_syndrome_calc_if bus ();

  rs_syndrome_calc dut (.clk(clk), .resetN(resetN), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  logic [23:0] expSyn = 24'h0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [3:0] gfExp(input int e);
    case (e % 15)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h4;  3: return 4'h8;
      4: return 4'h3;  5: return 4'h6;  6: return 4'hC;  7: return 4'hB;
      8: return 4'h5;  9: return 4'hA; 10: return 4'h7; 11: return 4'hE;
      12: return 4'hF; 13: return 4'hD; default: return 4'h9;
    endcase
  endfunction

  function automatic int gfLog(input logic [3:0] a);
    for (int i = 0; i < 15; i++) if (gfExp(i) == a) return i;
    return 0;
  endfunction

  function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
    if (a == 4'h0 || b == 4'h0) return 4'h0;
    return gfExp(gfLog(a) + gfLog(b));
  endfunction

  // Sj = sum_i r_i * alpha^(i*j)
  function automatic logic [23:0] modelSyn(input logic [59:0] w);
    logic [23:0] res;
    logic [3:0]  s;
    res = '0;
    for (int j = 1; j <= 6; j++) begin
      s = 4'h0;
      for (int i = 0; i < 15; i++) s ^= gfMul(w[4*i +: 4], gfExp(i * j));
      res[4*(j-1) +: 4] = s;
    end
    return res;
  endfunction

  // Systematic codeword: message in r14..r6, remainder of m(x)x^6 mod g(x) in r5..r0.
  function automatic logic [59:0] encode(input logic [35:0] msg);
    logic [3:0]  g [7];
    logic [3:0]  ng [7];
    logic [3:0]  rem [6];
    logic [3:0]  fb;
    logic [59:0] w;
    for (int k = 0; k < 7; k++) g[k] = (k == 0) ? 4'h1 : 4'h0;
    for (int j = 1; j <= 6; j++) begin
      for (int k = 0; k < 7; k++)
        ng[k] = ((k > 0) ? g[k-1] : 4'h0) ^ gfMul(g[k], gfExp(j));
      for (int k = 0; k < 7; k++) g[k] = ng[k];
    end
    for (int k = 0; k < 6; k++) rem[k] = 4'h0;
    w = '0;
    for (int idx = 0; idx < 9; idx++) begin
      fb = msg[4*(8-idx) +: 4] ^ rem[5];
      for (int k = 5; k > 0; k--) rem[k] = rem[k-1] ^ gfMul(fb, g[k]);
      rem[0] = gfMul(fb, g[0]);
      w[4*(14-idx) +: 4] = msg[4*(8-idx) +: 4];
    end
    for (int k = 0; k < 6; k++) w[4*k +: 4] = rem[k];
    return w;
  endfunction

  // Result and ready/valid relationship checked on every meaningful cycle.
  always @(negedge clk) begin
    if (resetN) begin
      check("readyVsValid", {23'd0, bus.symReady}, {23'd0, ~bus.syndromeValid});
      if (bus.syndromeValid) begin
        check("syndromeOut", bus.syndromeOut, expSyn);
        check("errorDetected", {23'd0, bus.errorDetected}, {23'd0, |expSyn});
      end
    end
  end

  task automatic sendWord(input logic [59:0] w, input bit gaps);
    for (int i = 14; i >= 0; i--) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.symValid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
        check("busyInGap", {23'd0, bus.busy}, (i == 14) ? 24'd0 : 24'd1);
      end
      bus.symValid = 1'b1;
      bus.symIn    = w[4*i +: 4];
      check("symReadyAccum", {23'd0, bus.symReady}, 24'd1);
      @(posedge clk); #1;
    end
    bus.symValid = 1'b0;
    check("validLatency", {23'd0, bus.syndromeValid}, 24'd1);
  endtask

  task automatic finishWord();
    @(posedge clk); #1;
    check("validFall", {23'd0, bus.syndromeValid}, 24'd0);
    check("readyReturn", {23'd0, bus.symReady}, 24'd1);
    check("busyIdle", {23'd0, bus.busy}, 24'd0);
  endtask

  task automatic runWord(input string tag, input logic [59:0] w, input logic [23:0] lit,
                         input bit useLit, input bit gaps);
    expSyn = modelSyn(w);
    if (useLit) check({"model_", tag}, expSyn, lit);
    sendWord(w, gaps);
    check({"syn_", tag}, bus.syndromeOut, expSyn);
    finishWord();
    $display("word %s syndrome=%h errorDetected=%0b", tag, expSyn, |expSyn);
  endtask

  logic [59:0] zeroWord, r0Word, r1Word, r14Word, cw, errWord;
  logic [35:0] msg;

  initial begin
    resetN = 1'b0;
    bus.symIn = 4'h0;
    bus.symValid = 1'b0;
    bus.syndromeReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rstSymReady", {23'd0, bus.symReady}, 24'd1);
    check("rstValid", {23'd0, bus.syndromeValid}, 24'd0);
    check("rstSyn", bus.syndromeOut, 24'd0);
    check("rstErr", {23'd0, bus.errorDetected}, 24'd0);
    check("rstBusy", {23'd0, bus.busy}, 24'd0);
    resetN = 1'b1;

    zeroWord = '0;
    r0Word = '0;  r0Word[3:0] = 4'h1;
    r1Word = '0;  r1Word[7:4] = 4'h1;
    r14Word = '0; r14Word[59:56] = 4'h1;
    runWord("zero", zeroWord, 24'h000000, 1'b1, 1'b0);
    runWord("r0", r0Word, 24'h111111, 1'b1, 1'b0);
    runWord("r1", r1Word, 24'hC63842, 1'b1, 1'b0);
    runWord("r14", r14Word, 24'hA7EFD9, 1'b1, 1'b0);

    msg = {4'hC, 4'hA, 4'h2, 4'hA, 4'h4, 4'h1, 4'h6, 4'hF, 4'hB};
    cw = encode(msg);
    runWord("codeword", cw, 24'h000000, 1'b1, 1'b0);
    errWord = cw;
    errWord[51:48] ^= 4'h5;
    errWord[31:28] ^= 4'hA;
    errWord[11:8]  ^= 4'h3;
    runWord("err3", errWord, 24'h0, 1'b0, 1'b0);
    runWord("err3Gaps", errWord, 24'h0, 1'b0, 1'b1);
    runWord("r1Gaps", r1Word, 24'hC63842, 1'b1, 1'b1);

    // Backpressure: result held, incoming symbols refused.
    bus.syndromeReady = 1'b0;
    expSyn = modelSyn(r14Word);
    sendWord(r14Word, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.symValid = 1'b1;
      bus.symIn = 4'hF;
      @(posedge clk); #1;
      check("bpStable", bus.syndromeOut, 24'hA7EFD9);
      check("bpReady", {23'd0, bus.symReady}, 24'd0);
      check("bpBusy", {23'd0, bus.busy}, 24'd1);
    end
    bus.symValid = 1'b0;
    bus.syndromeReady = 1'b1;
    finishWord();
    $display("word backpressure syndrome=%h", expSyn);
    runWord("afterBp", r0Word, 24'h111111, 1'b1, 1'b0);

    // Reset in the middle of a word discards the partial accumulation.
    for (int i = 0; i < 7; i++) begin
      bus.symValid = 1'b1;
      bus.symIn = 4'h7;
      @(posedge clk); #1;
    end
    bus.symValid = 1'b0;
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    check("midRstBusy", {23'd0, bus.busy}, 24'd0);
    check("midRstSyn", bus.syndromeOut, 24'd0);
    check("midRstValid", {23'd0, bus.syndromeValid}, 24'd0);
    runWord("afterRst", r0Word, 24'h111111, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

Symbol-serial syndrome calculator for the RS(15,9) code over GF(16) with primitive polynomial x^4+x+1 (alpha^4 = 4'b0011). It takes a received 15-symbol word one 4-bit symbol per cycle and produces the six syndromes S1..S6 = r(alpha^1..alpha^6), plus an error-detected flag. It sits on the receive side, between the channel or packed received word and the key-equation stage of the decoder. It is the checking counterpart to the encoding controller.

## Interface
Parameters: none. The code is fixed at n=15, k=9, 2t=6, m=4.

Ports:
- clk  in  1  rising-edge clock, single clock domain
- resetN  in  1  reset, synchronous, active-low
- symIn  in  4  received symbol, GF(16) polynomial basis (bit0 = alpha^0)
- symValid  in  1  symIn is valid this cycle
- symReady  out  1  block accepts a symbol this cycle
- syndromeOut  out  24  {S6,S5,S4,S3,S2,S1}; S1 at [3:0], S6 at [23:20]
- syndromeValid  out  1  syndromeOut and errorDetected are valid
- syndromeReady  in  1  downstream accepts the result
- errorDetected  out  1  high when any Sj != 0; qualified by syndromeValid
- busy  out  1  high whenever state != IDLE

## Operation
Symbol order:
- A word is 15 symbols, highest position first: r14, r13, …, r0.
- For a packed 60-bit word w, symbol r_i = w[4i+3:4i], so w[59:56] is sent first.

Handshake:
- A symbol is accepted on a rising edge where symValid && symReady.
- A result is consumed on a rising edge where syndromeValid && syndromeReady.
- symValid while symReady=0 is ignored and nothing is stored.

State machine: IDLE, ACCUM, HOLD.
- IDLE: symReady=1, busy=0. On accept: Sj <= symIn for all j, cnt <= 1, go to ACCUM.
- ACCUM: symReady=1. On accept: Sj <= gfMulConst(Sj, alpha^j) ^ symIn, cnt <= cnt+1. When the accepted symbol is the 15th (cnt==14 before the increment), go to HOLD.
- HOLD: symReady=0, syndromeValid=1. On a consume, go to IDLE.
- Gaps (symValid=0) in ACCUM hold all state indefinitely; there is no timeout.

Arithmetic:
- Horner evaluation. Each Sj is a 4-bit register; cnt is a 4-bit register with range 0..14.
- gfMulConst is a fixed XOR network built by repeated alpha-multiplication: mulAlpha(a) = {a[2:0],1'b0} ^ (a[3] ? 4'b0011 : 4'b0000). alpha^j is applied as j chained mulAlpha steps (j=1..6), or an equivalent flattened network.
- No general GF multiplier.
- errorDetected = |syndromeOut, computed from the registered syndromes.

Boundary conditions:
- Synchronous reset (resetN=0 at a rising edge), including mid-word: state=IDLE, cnt=0, all Sj=0, syndromeValid=0, busy=0. A partial word is discarded.
- HOLD: syndromeOut and errorDetected stay stable until consumed, and input symbols are not accepted.
- Consume and a new symbol never occur in the same cycle, because symReady=0 in HOLD.

## Timing
Reset values:
- symReady=1, syndromeValid=0, syndromeOut=0, errorDetected=0, busy=0.
- symReady=1 is the first value after a reset edge; it is a combinational decode of state==IDLE/ACCUM.

Throughput:
- 1 symbol per cycle.
- Minimum word period is 16 cycles: 15 accepts plus 1 cycle for the HOLD consume, with syndromeReady held high.

Latency and handshake timing:
- syndromeValid rises in the cycle after the edge that accepted r0.
- syndromeValid falls in the cycle after the consume edge.
- symReady returns to 1 in the same cycle that syndromeValid falls.
- All outputs are registered or decoded from registered state. There is no combinational path from symValid or syndromeReady to any output.

## Test plan
- All-zero word, 15 back-to-back symbols, syndromeReady=1 -> syndromeValid=1 exactly 1 cycle after the 15th accept; syndromeOut=24'h000000, errorDetected=0.
- Zero word with r0=4'h1 (last symbol) -> syndromeOut=24'h111111, errorDetected=1.
- Zero word with r1=4'h1 -> syndromeOut=24'hC63842. Zero word with r14=4'h1 (first symbol) -> syndromeOut=24'hA7EFD9.
- encodingContV2 codeword for message {alpha^6, alpha^9, alpha^1, alpha^9, alpha^2, alpha^0, alpha^5, alpha^12, alpha^7}, streamed as above -> syndromeOut=0, errorDetected=0. The same word XOR a 3-symbol error pattern -> errorDetected=1, and syndromeOut equals a golden r(alpha^j) model.
- Backpressure: hold syndromeReady=0 for 5 cycles in HOLD while driving symValid=1 -> syndromeOut stable, symReady=0, no symbol consumed. Release -> IDLE next cycle.
- Inject random symValid gaps mid-word -> same syndromes as gapless. Assert resetN=0 for 1 cycle after 7 symbols, then send the r0=1 word -> syndromeOut=24'h111111.
